pmu_seq: RTL

Parametrised multi-domain power management sequencer. It is the successor to the single-domain idle-driven isolation/power-switch controller. Each of NUM_DOM domains has an independent FSM that takes the domain down after a programmable run of idle cycles: isolate, optional retention save, power off. It brings the domain back up on wake, with a power-good handshake, a timeout and an optional retention restore. Sits between the ALU datapath idle detectors and the power switch/isolation cells.

---
 rtl/pmu_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pmu_seq.sv
// pmu_seq: per-domain idle-driven power sequencer (isolate, power off, wake with ack/timeout).
// Define PMU_RETENTION_EN to add the retention SAVE/RESTORE states and their pulses.
module pmu_seq #(
    parameter int unsigned NUM_DOM     = 4,
    parameter int unsigned IDLE_THRESH = 2,
    parameter int unsigned ISO_SETUP   = 1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DOM-1:0] i_idle,
    input  logic [NUM_DOM-1:0] i_pwr_ack,
    output logic [NUM_DOM-1:0] o_iso_en,
    output logic [NUM_DOM-1:0] o_pwr_off,
    output logic [NUM_DOM-1:0] o_ret_save,
    output logic [NUM_DOM-1:0] o_ret_restore,
    output logic [NUM_DOM-1:0] o_dom_on,
    output logic [NUM_DOM-1:0] o_pwr_err,
    output logic               o_busy
);
    localparam int unsigned MAX_IS  = (IDLE_THRESH > ISO_SETUP) ? IDLE_THRESH : ISO_SETUP;
    localparam int unsigned MAX_CNT = (MAX_IS > ACK_TIMEOUT) ? MAX_IS : ACK_TIMEOUT;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_THRESH);
    localparam logic [CW-1:0] ISO_LIM  = CW'(ISO_SETUP);
    localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_TIMEOUT);

`ifdef PMU_RETENTION_EN
    typedef enum logic [2:0] {StOn, StIso, StSave, StOff, StUp, StRestore} state_e;
`else
    typedef enum logic [2:0] {StOn, StIso, StOff, StUp} state_e;
`endif

    logic [NUM_DOM-1:0] w_iso;
    logic [NUM_DOM-1:0] w_off;
    logic [NUM_DOM-1:0] w_on;
    logic [NUM_DOM-1:0] w_err;
    logic [NUM_DOM-1:0] w_save;
    logic [NUM_DOM-1:0] w_restore;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
        state_e        r_state;
        state_e        w_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_d;
        logic [CW-1:0] w_cnt_inc;
        logic          w_err_set;
        logic          r_iso;
        logic          r_off;
        logic          r_on;
        logic          r_err;

        // One shared counter: idle run in ON, setup time in ISO, ack wait in UP.
        assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

        always_comb begin
            w_nxt     = r_state;
            w_cnt_d   = r_cnt;
            w_err_set = 1'b0;
            unique case (r_state)
                StOn: begin
                    if (!i_idle[g]) begin
                        w_cnt_d = '0;
                    end else if (w_cnt_inc >= IDLE_LIM) begin
                        w_cnt_d = '0;
                        w_nxt   = StIso;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StIso: begin
                    if (w_cnt_inc >= ISO_LIM) begin
                        w_cnt_d = '0;
`ifdef PMU_RETENTION_EN
                        w_nxt   = StSave;
`else
                        w_nxt   = StOff;
`endif
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
`ifdef PMU_RETENTION_EN
                StSave: begin
                    w_cnt_d = '0;
                    w_nxt   = StOff;
                end
                StRestore: begin
                    w_cnt_d = '0;
                    w_nxt   = StOn;
                end
`endif
                StOff: begin
                    w_cnt_d = '0;
                    if (!i_idle[g]) begin
                        w_nxt = StUp;
                    end
                end
                StUp: begin
                    if (i_pwr_ack[g]) begin
                        w_cnt_d = '0;
`ifdef PMU_RETENTION_EN
                        w_nxt   = StRestore;
`else
                        w_nxt   = StOn;
`endif
                    end else if (w_cnt_inc >= ACK_LIM) begin
                        w_cnt_d   = '0;
                        w_err_set = 1'b1;
                        w_nxt     = StOff;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    w_cnt_d = '0;
                    w_nxt   = StOn;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the same edge as the state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= StOn;
                r_cnt   <= '0;
                r_iso   <= 1'b0;
                r_off   <= 1'b0;
                r_on    <= 1'b1;
                r_err   <= 1'b0;
            end else begin
                r_state <= w_nxt;
                r_cnt   <= w_cnt_d;
                r_iso   <= (w_nxt != StOn);
                r_off   <= (w_nxt == StOff);
                r_on    <= (w_nxt == StOn);
                r_err   <= r_err | w_err_set;
            end
        end

`ifdef PMU_RETENTION_EN
        logic r_save;
        logic r_restore;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_save    <= 1'b0;
                r_restore <= 1'b0;
            end else begin
                r_save    <= (w_nxt == StSave);
                r_restore <= (w_nxt == StRestore);
            end
        end

        assign w_save[g]    = r_save;
        assign w_restore[g] = r_restore;
`else
        assign w_save[g]    = 1'b0;
        assign w_restore[g] = 1'b0;
`endif

        assign w_iso[g] = r_iso;
        assign w_off[g] = r_off;
        assign w_on[g]  = r_on;
        assign w_err[g] = r_err;
    end

    assign o_iso_en      = w_iso;
    assign o_pwr_off     = w_off;
    assign o_dom_on      = w_on;
    assign o_pwr_err     = w_err;
    assign o_ret_save    = w_save;
    assign o_ret_restore = w_restore;
    assign o_busy        = |(~(w_on | w_off));

endmodule
